// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two write ports (port 1 wins on collision),
// NUM_RD registered read ports with enables, optional write-to-read bypass and hardwired r0.
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_q;
    logic [NUM_RD*DATA_W-1:0] rd_d;
    logic [ADDR_W-1:0]        ra_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 32'sd0) && (a == {ADDR_W{1'b0}});
    endfunction

    // Next memory state; out-of-range write addresses never match any row
    always_comb begin
        for (int i = 32'sd0; i < DEPTH; i++) begin
            if ((ZERO_REG != 32'sd0) && (i == 32'sd0)) begin
                mem_d[i] = {DATA_W{1'b0}};
            end else if (we1 && (waddr1 == ADDR_W'(i))) begin
                mem_d[i] = wdata1;
            end else if (we0 && (waddr0 == ADDR_W'(i))) begin
                mem_d[i] = wdata0;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Next read-port state, priority: range, zero reg, bypass port 1, bypass port 0, storage
    always_comb begin
        rd_d = rd_q;
        ra_s = {ADDR_W{1'b0}};
        for (int k = 32'sd0; k < NUM_RD; k++) begin
            ra_s = rd_addr[k*ADDR_W +: ADDR_W];
            if (!rd_en[k]) begin
                rd_d[k*DATA_W +: DATA_W] = rd_q[k*DATA_W +: DATA_W];
            end else if (!in_range(ra_s)) begin
                rd_d[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (is_zero_reg(ra_s)) begin
                rd_d[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if ((BYPASS != 32'sd0) && we1 && (waddr1 == ra_s)) begin
                rd_d[k*DATA_W +: DATA_W] = wdata1;
            end else if ((BYPASS != 32'sd0) && we0 && (waddr0 == ra_s)) begin
                rd_d[k*DATA_W +: DATA_W] = wdata0;
            end else begin
                rd_d[k*DATA_W +: DATA_W] = mem_q[ra_s];
            end
        end
    end

    // State registers; reset clears storage and read outputs immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            rd_q <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule
